sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//   Parametrised synchronous FIFO, successor of the fixed 32-bit sync FIFO.
//   Adds configurable depth, fill count, almost-full/almost-empty thresholds
//   and overflow/underflow error pulses. Also adds an optional first-word-fall-through read mode.
//   Used as the general buffering primitive between single-clock pipeline stages.
// PARAMETERS
//   DATA_WIDTH  32  bits per entry
//   DEPTH       16  number of entries; power of two, >= 4
//   AFULL_THR   12  almost_full_o asserted when count >= AFULL_THR (1..DEPTH)
//   AEMPTY_THR   2  almost_empty_o asserted when count <= AEMPTY_THR (0..DEPTH-1)
// PORTS
//   clk_i           in   1            clock, all logic on rising edge
//   rst_n_i         in   1            synchronous reset, active low
//   write_i         in   1            write request
//   wr_data_i       in   DATA_WIDTH   write data, sampled with write_i
//   read_i          in   1            read request
//   rd_data_o       out  DATA_WIDTH   read data
//   full_o          out  1            DEPTH entries stored
//   empty_o         out  1            0 entries stored
//   almost_full_o   out  1            count >= AFULL_THR
//   almost_empty_o  out  1            count <= AEMPTY_THR
//   count_o         out  ADDR_W+1     entries stored, 0..DEPTH
//   overflow_o      out  1            1-cycle pulse: write_i while full_o
//   underflow_o     out  1            1-cycle pulse: read_i while empty_o
// BEHAVIOUR
//   - ADDR_W = $clog2(DEPTH). Pointers are ADDR_W+1 bits and wrap naturally. The MSB differs when full.
//   - The block has one clock and a synchronous, active-low reset (clk_i, rst_n_i).
//   - Reset state: pointers=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0,
//     almost_empty_o=1, rd_data_o=0, overflow_o=0, underflow_o=0. Memory contents are not cleared.
//   - All flags and count_o are derived from registered state and are valid in the same cycle as that state.
//   - A write is accepted iff write_i && !full_o. A read is accepted iff read_i && !empty_o.
//   - Flags are sampled pre-edge. When full, a write is rejected even if a read is accepted in the same cycle.
//   - When empty, a read is rejected even if a write is accepted in the same cycle.
//   - Accepted read and write in the same cycle: count_o is unchanged and both pointers advance.
//   - A rejected write sets overflow_o high on the next cycle for one cycle. State is unchanged.
//   - A rejected read sets underflow_o high on the next cycle for one cycle. rd_data_o holds.
//   - count_o changes by +1, -1 or 0 per cycle. It never exceeds DEPTH and never goes below 0.
//   - A reset asserted mid-operation discards all entries. The reset state appears on the cycle after the reset edge.
// CONFIGURATION
//   Macro SYNC_FIFO_FWFT_EN:
//   - Undefined (standard mode): rd_data_o is a register loaded with the head entry on the edge that accepts a read.
//     It is valid 1 cycle after the read and holds until the next accepted read.
//   - Defined (first-word-fall-through): rd_data_o always shows the head entry while !empty_o.
//     read_i pops the entry, so data is valid with 0-cycle latency.
//     While empty_o, rd_data_o holds its last value (0 after reset).
//     A write to an empty FIFO makes the entry visible 1 cycle later.
// STRUCTURE
//   - Package sync_fifo_pkg holds:
//     - the localparam function for ADDR_W;
//     - typedef fifo_ptr_t (ADDR_W+1 bits) and typedef fifo_cnt_t.
//   - Sub-module sync_fifo_ram:
//     - DEPTH x DATA_WIDTH register array with one synchronous write port and one read port;
//     - the read port is registered in standard mode and asynchronous in FWFT mode.
//   - The top level holds the pointers, the count, the flags and the error pulses.
// TESTING (DATA_WIDTH=32, DEPTH=8, AFULL_THR=6, AEMPTY_THR=1)
//   1. Reset, then idle -> empty_o=1, almost_empty_o=1, full_o=0, count_o=0, rd_data_o=0.
//   2. Write 8 words 0xA0..0xA7 on consecutive cycles:
//      -> almost_empty_o drops after the 2nd write, almost_full_o rises after the 6th,
//         full_o=1 and count_o=8 after the 8th.
//      Then read 8 words -> 0xA0..0xA7 in order (1-cycle latency in standard mode, 0 in FWFT),
//      and empty_o=1 at the end.
//   3. When full, write 0xFF -> overflow_o pulses for 1 cycle, count_o stays 8,
//      and 0xFF is never read back.
//   4. When empty, read -> underflow_o pulses, rd_data_o is unchanged, count_o stays 0.
//      Then read+write of 0x11 in the same cycle -> count_o=1 and the read is rejected.
//   5. With count=4, hold read+write together for 20 cycles (pointer wrap):
//      -> count_o stays 4 and the data order is preserved across the wrap.
//   6. With count=5, assert rst_n_i=0 for 1 cycle -> reset state on the next cycle.
//      A later write of 0x22 followed by a read returns 0x22.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Package: sync_fifo_pkg
// Shared sizing helper and default pointer/count types for the sync_fifo_flags
// family. The typedefs are sized for the default 16-entry configuration.
// Parameterised instances size their own pointers with fifo_addr_w().
package sync_fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DEPTH = 16;

    // Address width needed to index 'depth' entries (depth is a power of two)
    function automatic int unsigned fifo_addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned FIFO_DEFAULT_ADDR_W = fifo_addr_w(FIFO_DEFAULT_DEPTH);

    // Pointer carries one extra wrap bit so full and empty can be told apart
    typedef logic [FIFO_DEFAULT_ADDR_W:0] fifo_ptr_t;
    // Fill count spans 0..DEPTH inclusive
    typedef logic [FIFO_DEFAULT_ADDR_W:0] fifo_cnt_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Module: sync_fifo_ram
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// read port. Optional feature macro: SYNC_FIFO_FWFT_EN.
//   Undefined : read port is registered, loaded when re_i is high, reset to 0.
//   Defined   : read port is asynchronous (rst_n_i / re_i ports not present).
// Ports:
//   clk_i    clock
//   rst_n_i  synchronous active-low reset of the read register (standard mode)
//   re_i     read enable, loads the read register (standard mode)
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk_i,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                  rst_n_i,
    input  logic                  re_i,
`endif
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage array write; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata_o = mem_q[raddr_i];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read port: captures the head entry on an accepted read
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Module: sync_fifo_flags
// Parametrised synchronous FIFO with fill count, almost-full/almost-empty
// flags and one-cycle overflow/underflow error pulses.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read).
// Ports:
//   clk_i           clock, rising edge
//   rst_n_i         synchronous active-low reset
//   write_i         write request; wr_data_i sampled with it
//   wr_data_i       write data
//   read_i          read request
//   rd_data_o       read data (1-cycle latency, or head entry in FWFT mode)
//   full_o          DEPTH entries stored
//   empty_o         no entries stored
//   almost_full_o   count_o >= AFULL_THR
//   almost_empty_o  count_o <= AEMPTY_THR
//   count_o         entries stored, 0..DEPTH
//   overflow_o      one-cycle pulse after a write request while full
//   underflow_o     one-cycle pulse after a read request while empty
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int AFULL_THR  = 12,
    parameter  int AEMPTY_THR = 2,
    localparam int ADDR_W     = fifo_addr_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  write_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  read_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_W:0]       count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AFULL_C  = AFULL_THR[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_THR[ADDR_W:0];

    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc_s, rd_acc_s;
    logic                  full_s, empty_s;
    logic [ADDR_W:0]       count_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // Count and flags come straight from the registered pointers; the MSB
    // differs exactly when the write pointer has lapped the read pointer.
    assign count_s = wr_ptr_q - rd_ptr_q;
    assign full_s  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    // Flags are pre-edge: a simultaneous read never frees room for a write
    // when full, nor does a simultaneous write supply data to a read when empty.
    assign wr_acc_s = write_i && !full_s;
    assign rd_acc_s = read_i && !empty_s;

    // Next-state for pointers and error pulses
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = write_i && full_s;
        underflow_d = read_i && empty_s;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= {(ADDR_W+1){1'b0}};
            rd_ptr_q    <= {(ADDR_W+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
`ifndef SYNC_FIFO_FWFT_EN
        .rst_n_i (rst_n_i),
        .re_i    (rd_acc_s),
`endif
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] last_q;

    // Remembers the most recently popped entry so the output holds while empty
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= {DATA_WIDTH{1'b0}};
        end else if (rd_acc_s) begin
            last_q <= ram_rdata_s;
        end else begin
            last_q <= last_q;
        end
    end

    assign rd_data_o = empty_s ? last_q : ram_rdata_s;
`else
    assign rd_data_o = ram_rdata_s;
`endif

    assign full_o         = full_s;
    assign empty_o        = empty_s;
    assign count_o        = count_s;
    assign almost_full_o  = (count_s >= AFULL_C);
    assign almost_empty_o = (count_s <= AEMPTY_C);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench: tb_sync_fifo_flags
// Scoreboard-based bench for sync_fifo_flags (DEPTH=8, AFULL_THR=6,
// AEMPTY_THR=1). Follows SYNC_FIFO_FWFT_EN for the read-data expectation.
module tb_sync_fifo_flags;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk_i;
    logic          rst_n_i;
    logic          write_i;
    logic [DW-1:0] wr_data_i;
    logic          read_i;
    logic [DW-1:0] rd_data_o;
    logic          full_o, empty_o, almost_full_o, almost_empty_o;
    logic [3:0]    count_o;
    logic          overflow_o, underflow_o;

    int            n_checks;
    int            n_errors;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd;
    logic          exp_ov, exp_un;

    sync_fifo_flags #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_THR  (6),
        .AEMPTY_THR (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .write_i        (write_i),
        .wr_data_i      (wr_data_i),
        .read_i         (read_i),
        .rd_data_o      (rd_data_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    // Free-running clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare every observable output against the scoreboard model
    task automatic check_all();
        int            cnt;
        logic [DW-1:0] exp_rd;
        cnt = exp_q.size();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = (cnt > 0) ? exp_q[0] : last_rd;
`else
        exp_rd = last_rd;
`endif
        check_eq("count",        {28'd0, count_o},          cnt);
        check_eq("full",         {31'd0, full_o},           {31'd0, cnt == DEPTH});
        check_eq("empty",        {31'd0, empty_o},          {31'd0, cnt == 0});
        check_eq("almost_full",  {31'd0, almost_full_o},    {31'd0, cnt >= 6});
        check_eq("almost_empty", {31'd0, almost_empty_o},   {31'd0, cnt <= 1});
        check_eq("overflow",     {31'd0, overflow_o},       {31'd0, exp_ov});
        check_eq("underflow",    {31'd0, underflow_o},      {31'd0, exp_un});
        check_eq("rd_data",      rd_data_o,                 exp_rd);
    endtask

    // One clock cycle of stimulus; model updated from pre-edge occupancy
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        int   cnt;
        logic wacc, racc;
        cnt       = exp_q.size();
        write_i   = w;
        wr_data_i = d;
        read_i    = r;
        wacc      = w && (cnt < DEPTH);
        racc      = r && (cnt > 0);
        @(posedge clk_i);
        #1;
        exp_ov = w && (cnt == DEPTH);
        exp_un = r && (cnt == 0);
        if (racc) last_rd = exp_q.pop_front();
        if (wacc) exp_q.push_back(d);
        write_i = 1'b0;
        read_i  = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        write_i = 1'b0;
        read_i  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        exp_q.delete();
        last_rd = '0;
        exp_ov  = 1'b0;
        exp_un  = 1'b0;
        check_all();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n_i   = 1'b0;
        write_i   = 1'b0;
        read_i    = 1'b0;
        wr_data_i = '0;
        last_rd   = '0;
        exp_ov    = 1'b0;
        exp_un    = 1'b0;

        // 1: reset then idle
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);

        // 2: fill with A0..A7, then drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 32'hA0 + i, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        // 3: overflow when full, including with a simultaneous read
        for (int i = 0; i < 8; i++) step(1'b1, 32'hB0 + i, 1'b0);
        step(1'b1, 32'hFF, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hFE, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // 4: underflow when empty, then read+write on empty
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h11, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        // 5: steady read+write at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + i, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'hD0 + i, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        // 6: reset mid-operation with 5 entries, then reuse
        for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + i, 1'b0);
        do_reset();
        step(1'b1, 32'h22, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        // Randomised mix against the model
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
